// File: rtl/leds_rgb_sequencer.sv
// Illumination sequencer for the RGB LED PWM driver.
// On each accepted line-sync rising edge it walks the enabled colours in
// R, G, B order. For each colour it drives a one-hot RGB select, a START
// strobe, an exposure window, an END strobe and a dark gap.
// Optional feature macro: LEDS_SEQ_LINE_CNT_EN enables the completed-line
// counter on LINE_CNT. When the macro is undefined, LINE_CNT is tied to 0.
module leds_rgb_sequencer #(
  parameter int CNT_W    = 24,
  parameter int GAP_CLKS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             LINE_SYNC,
  input  logic [2:0]       COLOR_MASK,
  input  logic [CNT_W-1:0] EXPOSURE,
  input  logic             OVR_CLR,
  output logic             START,
  output logic             END,
  output logic [2:0]       RGB,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERRUN,
  output logic [15:0]      LINE_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STRT,
    S_ON,
    S_STOP,
    S_GAP
  } state_e;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CLKS);

  // Returns the highest-priority enabled colour as a one-hot value.
  // Mask bit order (R=bit2) matches the RGB select encoding.
  function automatic logic [2:0] first_color(input logic [2:0] mask);
    logic [2:0] sel;
    sel = 3'b000;
    if (mask[2])      sel = 3'b100;
    else if (mask[1]) sel = 3'b010;
    else if (mask[0]) sel = 3'b001;
    return sel;
  endfunction

  state_e           state_q, state_d;
  logic             sync_q;
  logic [2:0]       color_q, color_d;  // colour currently being exposed
  logic [2:0]       rem_q, rem_d;      // colours still to run on this line
  logic [CNT_W-1:0] exp_q, exp_d;      // latched exposure length, never 0
  logic [CNT_W-1:0] cnt_q, cnt_d;      // exposure counter, counts 1..exp_q
  logic [7:0]       gap_q, gap_d;      // gap counter, counts 1..GAP_CLKS
  logic             abort_q, abort_d;  // ENABLE dropped during this line
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             sync_rise;

  assign sync_rise = LINE_SYNC & ~sync_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    color_d = color_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    abort_d = abort_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (sync_rise && ENABLE && (COLOR_MASK != 3'b000)) begin
          color_d = first_color(COLOR_MASK);
          rem_d   = COLOR_MASK & ~first_color(COLOR_MASK);
          exp_d   = (EXPOSURE == '0) ? CNT_W'(1) : EXPOSURE;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = ENABLE ? S_STRT : S_IDLE;
      end
      S_STRT: begin
        if (ENABLE) begin
          state_d = S_ON;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (!ENABLE) begin
          state_d = S_STOP;
          abort_d = 1'b1;
        end else if (cnt_q == exp_q) begin
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (!ENABLE || abort_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = 8'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (!ENABLE || abort_q) begin
            state_d = S_IDLE;
          end else if (rem_q != 3'b000) begin
            color_d = first_color(rem_q);
            rem_d   = rem_q & ~first_color(rem_q);
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + 8'd1;
          if (!ENABLE) abort_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    rgb_d   = ((state_d == S_SETUP) || (state_d == S_STRT) ||
               (state_d == S_ON)    || (state_d == S_STOP)) ? color_d : 3'b000;
    start_d = (state_d == S_STRT);
    end_d   = (state_d == S_STOP);
    busy_d  = (state_d != S_IDLE);

    // A fresh overrun takes priority over a clear in the same cycle.
    if (sync_rise && (state_q != S_IDLE)) ovr_d = 1'b1;
    else if (OVR_CLR)                     ovr_d = 1'b0;
    else                                  ovr_d = ovr_q;
  end

  // FSM state, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      state_q <= S_IDLE;
      sync_q  <= 1'b0;
      color_q <= 3'b000;
      rem_q   <= 3'b000;
      exp_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= 8'd0;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      rgb_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= LINE_SYNC;
      color_q <= color_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
      start_q <= start_d;
      end_q   <= end_d;
      rgb_q   <= rgb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign START   = start_q;
  assign END     = end_q;
  assign RGB     = rgb_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign OVERRUN = ovr_q;

`ifdef LEDS_SEQ_LINE_CNT_EN
  logic [15:0] line_cnt_q, line_cnt_d;

  // Count completed lines. The counter steps in the same cycle DONE rises.
  always_comb begin
    line_cnt_d = done_d ? (line_cnt_q + 16'd1) : line_cnt_q;
  end

  // Completed-line counter register.
  always_ff @(posedge CLK) begin
    if (RST) line_cnt_q <= 16'd0;
    else     line_cnt_q <= line_cnt_d;
  end

  assign LINE_CNT = line_cnt_q;
`else
  assign LINE_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_leds_rgb_sequencer.sv
// Self-checking bench for leds_rgb_sequencer.
// Expected per-cycle outputs come from a timing model of the line sequence.
// They are pushed to a scoreboard queue when a line is launched, and then
// popped and compared each cycle on the falling clock edge.
module tb_leds_rgb_sequencer;

  localparam int CNT_W = 6;
  localparam int GAP   = 4;
`ifdef LEDS_SEQ_LINE_CNT_EN
  localparam bit LCNT_EN = 1'b1;
`else
  localparam bit LCNT_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             ENABLE;
  logic             LINE_SYNC;
  logic [2:0]       COLOR_MASK;
  logic [CNT_W-1:0] EXPOSURE;
  logic             OVR_CLR;
  logic             START;
  logic             END;
  logic [2:0]       RGB;
  logic             BUSY;
  logic             DONE;
  logic             OVERRUN;
  logic [15:0]      LINE_CNT;

  leds_rgb_sequencer #(.CNT_W(CNT_W), .GAP_CLKS(GAP)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .LINE_SYNC(LINE_SYNC),
    .COLOR_MASK(COLOR_MASK), .EXPOSURE(EXPOSURE), .OVR_CLR(OVR_CLR),
    .START(START), .END(END), .RGB(RGB), .BUSY(BUSY), .DONE(DONE),
    .OVERRUN(OVERRUN), .LINE_CNT(LINE_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic [2:0]  rgb;
    logic        busy;
    logic        done;
    logic        ovr;
    logic [15:0] lcnt;
  } obs_t;

  typedef struct {
    logic [2:0] mask;
    int         e;
  } vec_t;

  obs_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_lines = 16'd0;
  logic        model_ovr   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t sample_dut();
    obs_t o;
    o.start = START;
    o.stop  = END;
    o.rgb   = RGB;
    o.busy  = BUSY;
    o.done  = DONE;
    o.ovr   = OVERRUN;
    o.lcnt  = LINE_CNT;
    return o;
  endfunction

  // Cycle t after the sync edge at t=0. Each colour period is
  // SETUP(1) + STRT(1) + ON(E) + STOP(1) + GAP(GAP) cycles.
  function automatic obs_t model_at(input logic [2:0] mask, input int e, input int t);
    obs_t       o;
    logic [2:0] cols[3];
    int         k, ee, p, u, j, r;
    o  = '0;
    k  = 0;
    for (int b = 2; b >= 0; b--) begin
      if (mask[b]) begin
        cols[k] = 3'b000;
        cols[k][b] = 1'b1;
        k++;
      end
    end
    ee = (e == 0) ? 1 : e;
    p  = ee + GAP + 3;
    if (t == 0) return o;
    u = t - 1;
    j = u / p;
    r = u % p;
    if (j < k) begin
      o.busy = 1'b1;
      if (r <= ee + 2) o.rgb = cols[j];
      if (r == 1)      o.start = 1'b1;
      if (r == ee + 2) o.stop = 1'b1;
    end else if ((j == k) && (r == 0)) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // Launch one line and compare every cycle against the model.
  // A negative cycle index disables each optional event:
  // second_t = extra sync edge, clr_t = OVR_CLR pulse,
  // drop_t = ENABLE low, rst_t = RST pulse.
  task automatic run_line(input string name, input logic [2:0] mask, input int e,
                          input int second_t, input int clr_t, input int drop_t, input int rst_t);
    int          k, ee, len;
    obs_t        o, act, exp;
    logic        ovr;
    logic [15:0] lines;
    k   = $countones(mask);
    ee  = (e == 0) ? 1 : e;
    len = k * (ee + GAP + 3) + 3;
    if (drop_t >= 0) len = drop_t + 6;
    if (rst_t >= 0)  len = rst_t + 5;
    COLOR_MASK = mask;
    EXPOSURE   = CNT_W'(e);
    ovr   = model_ovr;
    lines = model_lines;
    for (int t = 0; t < len; t++) begin
      o = model_at(mask, e, t);
      if ((drop_t >= 0) && (t > drop_t)) begin
        if (t == drop_t + 1) begin
          o       = '0;
          o.stop  = 1'b1;
          o.busy  = 1'b1;
          o.rgb   = model_at(mask, e, drop_t).rgb;
        end else begin
          o = '0;
        end
      end
      if ((rst_t >= 0) && (t > rst_t)) o = '0;
      if ((rst_t >= 0) && (t == rst_t + 1)) lines = 16'd0;
      if (o.done) lines = lines + 16'd1;
      o.lcnt = LCNT_EN ? lines : 16'd0;
      o.ovr  = ovr;
      if ((rst_t >= 0) && (t == rst_t)) ovr = 1'b0;
      else if (t == second_t)          ovr = 1'b1;
      else if (t == clr_t)             ovr = 1'b0;
      sb_q.push_back(o);
    end
    model_ovr   = ovr;
    model_lines = lines;

    for (int t = 0; t < len; t++) begin
      @(negedge CLK);
      act = sample_dut();
      exp = sb_q.pop_front();
      check($sformatf("%s t=%0d", name, t), 32'(act), 32'(exp));
      if (t == 0) LINE_SYNC = 1'b1;
      if (t == 2) begin
        LINE_SYNC  = 1'b0;
        COLOR_MASK = ~mask;
        EXPOSURE   = CNT_W'($urandom);
      end
      if (t == second_t)     LINE_SYNC = 1'b1;
      if (t == second_t + 2) LINE_SYNC = 1'b0;
      OVR_CLR = (t == clr_t);
      if (t == drop_t) ENABLE = 1'b0;
      RST = (t == rst_t);
    end
    ENABLE    = 1'b1;
    RST       = 1'b0;
    OVR_CLR   = 1'b0;
    LINE_SYNC = 1'b0;
  endtask

  // Pulse LINE_SYNC under the current ENABLE/COLOR_MASK and expect it ignored.
  task automatic expect_ignored(input string name);
    @(negedge CLK);
    LINE_SYNC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("%s busy c%0d", name, i), 32'(BUSY), 32'd0);
      check($sformatf("%s rgb c%0d", name, i), 32'(RGB), 32'd0);
    end
    LINE_SYNC = 1'b0;
    @(negedge CLK);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{mask: 3'b111, e: 10};
    vecs[1] = '{mask: 3'b010, e: 0};
    vecs[2] = '{mask: 3'b100, e: 1};
    vecs[3] = '{mask: 3'b001, e: 63};
    vecs[4] = '{mask: 3'b101, e: 2};
    vecs[5] = '{mask: 3'b011, e: 5};
    vecs[6] = '{mask: 3'b110, e: 0};

    RST        = 1'b1;
    ENABLE     = 1'b1;
    LINE_SYNC  = 1'b0;
    COLOR_MASK = 3'b000;
    EXPOSURE   = '0;
    OVR_CLR    = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset outputs", 32'(sample_dut()), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle after reset", 32'(sample_dut()), 32'd0);

    // Main function over the vector table.
    for (int i = 0; i < 7; i++) begin
      run_line($sformatf("vec%0d", i), vecs[i].mask, vecs[i].e, -1, -1, -1, -1);
    end

    // Edges ignored when disabled or with an empty mask.
    ENABLE     = 1'b0;
    COLOR_MASK = 3'b111;
    expect_ignored("disabled");
    ENABLE     = 1'b1;
    COLOR_MASK = 3'b000;
    expect_ignored("empty mask");

    // Overrun set by a second edge, cleared by OVR_CLR; a set in the same cycle as a clear wins.
    run_line("overrun", 3'b111, 10, 5, -1, -1, -1);
    run_line("ovr clear", 3'b010, 0, -1, 3, -1, -1);
    run_line("ovr set+clr", 3'b100, 2, 5, 5, -1, -1);

    // ENABLE dropped in the third ON cycle of G (t=22).
    run_line("abort", 3'b111, 10, -1, -1, 22, -1);

    // Reset during ON of R, then a normal line afterwards.
    run_line("reset mid", 3'b100, 10, -1, -1, -1, 5);
    run_line("after reset", 3'b111, 3, -1, -1, -1, -1);

    check("line count end", 32'(LINE_CNT), LCNT_EN ? 32'(model_lines) : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
